// File: rtl/sobel_frame_packer.sv
// sobel_frame_packer: packs gated Sobel results into an AXI4-Stream-style video stream with sof/eol tags
//   clk, rst_n              : clock, asynchronous active-low reset
//   pix_valid/zero/data     : result pixel in, pad flag forces data to 0
//   pix_ready               : FIFO has room (occupancy based only)
//   m_tvalid/tready/tdata   : output stream handshake and pixel
//   m_tuser/m_tlast         : start of frame / end of line tags
//   frame_done              : one-cycle pulse after the last beat of a frame is taken
//   overflow                : sticky, a pixel arrived while the FIFO was full
module sobel_frame_packer #(
    parameter int RAW_FRAME_COLNUM = 1920,
    parameter int RAW_FRAME_ROWNUM = 1080,
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_valid,
    input  logic                  pix_zero,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tuser,
    output logic                  m_tlast,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 3;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [11:0]   col_q, row_q, col_d, row_d;
    logic          alive_q, vld_q, vld_d, ovf_q, done_q;
    logic [EW-1:0] out_q, out_d, wr_entry, head;
    logic          wr, pop, col_end, row_end, load;
    assign pix_ready = alive_q && (count_q != (AW+1)'(FIFO_DEPTH));
    assign wr        = pix_valid && pix_ready;
    assign col_end   = col_q == 12'(RAW_FRAME_COLNUM - 1);
    assign row_end   = row_q == 12'(RAW_FRAME_ROWNUM - 1);
    assign wr_entry  = {col_end && row_end, col_q == 12'd0 && row_q == 12'd0, col_end,
                        pix_zero ? {DATA_WIDTH{1'b0}} : pix_data};
    // The output register mirrors the FIFO head; the entry stays counted until it is handshaked.
    assign pop       = vld_q && m_tready;
    assign head      = mem_q[vld_q ? rd_ptr_q + AW'(1) : rd_ptr_q];
    assign load      = vld_q ? (pop && count_q >= (AW+1)'(2)) : (count_q != '0);
    always_comb begin
        col_d   = wr ? (col_end ? 12'd0 : col_q + 12'd1) : col_q;
        row_d   = (wr && col_end) ? (row_end ? 12'd0 : row_q + 12'd1) : row_q;
        count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
        vld_d   = vld_q ? (pop ? load : 1'b1) : load;
        out_d   = load ? head : out_q;
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wr_entry;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            vld_q    <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            alive_q  <= 1'b1;
            wr_ptr_q <= wr_ptr_q + AW'(wr);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            col_q    <= col_d;
            row_q    <= row_d;
            vld_q    <= vld_d;
            out_q    <= out_d;
            ovf_q    <= ovf_q || (pix_valid && !pix_ready);
            done_q   <= pop && out_q[EW-1];
        end
    end
    assign m_tvalid   = vld_q;
    assign m_tdata    = out_q[DATA_WIDTH-1:0];
    assign m_tlast    = out_q[DATA_WIDTH];
    assign m_tuser    = out_q[DATA_WIDTH+1];
    assign frame_done = done_q;
    assign overflow   = ovf_q;
endmodule

// File: doc/sobel_frame_packer.md
Name: sobel_frame_packer

Overview:
- Output end of the Sobel pipeline. Takes the per-pixel result stream that is gated by the position calculator's valid flags, and turns it into an AXI4-Stream-style video stream.
- Forces pad pixels to zero and tags each pixel with start-of-frame (tuser) and end-of-line (tlast).
- Buffers pixels in a small FIFO so downstream backpressure is absorbed.
- Reports frame completion and sticky overflow.

Parameters:
RAW_FRAME_COLNUM, 1920, pixels per line (>=2)
RAW_FRAME_ROWNUM, 1080, lines per frame (>=2)
DATA_WIDTH, 8, result pixel width
FIFO_DEPTH, 16, FIFO entries; power of 2, >=4

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pix_valid  input  1  result pixel present (pos_valid from the position calculator)
pix_zero  input  1  pixel lies in the pad region (zero_valid); data is replaced by 0
pix_data  input  DATA_WIDTH  Sobel magnitude
pix_ready  output  1  FIFO can accept a pixel
m_tvalid  output  1  output beat valid
m_tready  input  1  downstream accepts beat
m_tdata  output  DATA_WIDTH  output pixel
m_tuser  output  1  first pixel of frame (row 0, col 0)
m_tlast  output  1  last pixel of line (col RAW_FRAME_COLNUM-1)
frame_done  output  1  one-cycle pulse after the final beat of a frame is transferred
overflow  output  1  sticky flag: a pixel arrived while the FIFO was full

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, including pix_ready. pix_ready rises to 1 on the first clock after rst_n deasserts. FIFO is empty, the 12-bit row/col counters are 0, overflow is 0.

Write side:
- A pixel is accepted when pix_valid && pix_ready.
- Stored entry is {eof, sof, eol, data}:
  - sof = (row==0 && col==0)
  - eol = (col==COLNUM-1)
  - eof = eol && (row==ROWNUM-1)
  - data = pix_zero ? 0 : pix_data
- Counters advance only on accept.
  - col wraps COLNUM-1 -> 0 and increments row.
  - row wraps ROWNUM-1 -> 0 when col wraps, so back-to-back frames need no gap.
- pix_ready = !full. It depends only on the occupancy count, never on m_tready. When full, a write is refused even in a cycle where a read occurs.
- pix_valid && !pix_ready: the pixel is dropped, counters hold, overflow is set to 1. overflow clears only on reset.

FIFO:
- Circular buffer with a read pointer, a write pointer and an occupancy count of log2(FIFO_DEPTH)+1 bits.
- Simultaneous read and write on a non-empty FIFO leaves the count unchanged.

Read side:
- Registered output stage with first-word-fall-through behaviour.
- Latency: a pixel accepted at edge N into an empty FIFO with an empty output stage shows m_tvalid=1 after edge N+1.
- The output register reloads when it is empty, or when m_tvalid && m_tready.
- Sustained throughput with m_tready=1 is 1 beat per cycle.
- While m_tvalid && !m_tready, m_tdata, m_tuser and m_tlast stay stable and m_tvalid stays high.
- m_tvalid drops when the output beat is taken and the FIFO is empty.

frame_done:
- Registered. High for exactly one cycle, in the cycle after the handshake of a beat whose eof bit is set.

Reset mid-frame:
- FIFO contents are discarded. Counters return to 0, so the next accepted pixel carries sof.

Test Plan:
(All with RAW_FRAME_COLNUM=4, RAW_FRAME_ROWNUM=3, FIFO_DEPTH=4, DATA_WIDTH=8.)
1. Reset values: hold rst_n=0 -> all outputs 0, including pix_ready; release -> pix_ready=1 on the next clock, m_tvalid=0, overflow=0.
2. Full frame, m_tready=1: push data 1..12 on consecutive cycles -> m_tdata=1..12 with 1-cycle latency and no bubbles; m_tuser=1 only on beat 1; m_tlast=1 on beats 4, 8, 12; frame_done=1 for one cycle, the cycle after beat 12.
3. Pad zeroing: frame with pix_zero=1 on pixels 1-4 and on col 0-1 of rows 1-2, data=0xFF everywhere -> those beats carry 0x00, the rest carry 0xFF; tags unchanged.
4. Backpressure and overflow: m_tready=0, push 1..5 -> pix_ready=0 after the 4th accept, pixel 5 dropped, overflow=1. Set m_tready=1 -> output 1,2,3,4 with data held stable while stalled. Next push is tagged as pixel 5 (col 0, row 1); overflow stays 1.
5. Frame wrap: push 24 pixels continuously -> m_tuser on beats 1 and 13; frame_done pulses after beats 12 and 24.
6. Reset mid-frame: push 5 pixels, m_tready=0, assert rst_n=0 -> m_tvalid=0, FIFO empty. After release, the next accepted pixel is output with m_tuser=1.
